// File: rtl/bus_ack_generator_if.sv
// Purpose: 68000 local-bus handshake bundle between the CPU/decoder side and
//          the acknowledge generator.
// Signals:
//   AS_L               CPU address strobe, already synchronous to the clock
//   OnChipRomSelect_H  decoder select, on-chip ROM
//   OnChipRamSelect_H  decoder select, on-chip RAM
//   IOSelect_H         decoder select, IO
//   CanBusSelect_H     decoder select, CAN controller
//   DramSelect_H       decoder select, DRAM
//   DramDtack_L        acknowledge from the DRAM controller
//   Dtack_L            data transfer acknowledge to the CPU
//   Berr_L             bus error to the CPU
//   CycleBusy_H        acknowledge FSM is not idle
// Modports: master = CPU/decoder side, slave = acknowledge generator.
interface bus_ack_generator_if;
    logic AS_L;
    logic OnChipRomSelect_H;
    logic OnChipRamSelect_H;
    logic IOSelect_H;
    logic CanBusSelect_H;
    logic DramSelect_H;
    logic DramDtack_L;
    logic Dtack_L;
    logic Berr_L;
    logic CycleBusy_H;

    modport master (
        output AS_L, OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H,
               CanBusSelect_H, DramSelect_H, DramDtack_L,
        input  Dtack_L, Berr_L, CycleBusy_H
    );

    modport slave (
        input  AS_L, OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H,
               CanBusSelect_H, DramSelect_H, DramDtack_L,
        output Dtack_L, Berr_L, CycleBusy_H
    );
endinterface

// File: rtl/bus_ack_generator.sv
// Purpose: Generates the 68000 DTACK_L with per-region wait states, passes the
//          DRAM controller acknowledge through, and raises BERR_L on unmapped
//          or hung cycles.
// Ports:
//   Clock    in   system clock, all logic on the rising edge
//   Reset_L  in   synchronous active-low reset
//   bus      slave modport of bus_ack_generator_if (strobe, selects,
//            DRAM acknowledge in; Dtack_L, Berr_L, CycleBusy_H out, registered)
// Build option: define BUS_TIMEOUT_EN to enable the bus-error timeout.
//   Without it Berr_L is tied high and DRAM/unmapped cycles wait for AS_L.
module bus_ack_generator #(
    parameter int unsigned ROM_WAIT = 1,
    parameter int unsigned RAM_WAIT = 1,
    parameter int unsigned IO_WAIT  = 3,
    parameter int unsigned CAN_WAIT = 6,
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                Clock,
    input  logic                Reset_L,
    bus_ack_generator_if.slave  bus
);

    localparam logic [CNT_W-1:0] ROM_W     = CNT_W'(ROM_WAIT);
    localparam logic [CNT_W-1:0] RAM_W     = CNT_W'(RAM_WAIT);
    localparam logic [CNT_W-1:0] IO_W      = CNT_W'(IO_WAIT);
    localparam logic [CNT_W-1:0] CAN_W     = CNT_W'(CAN_WAIT);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        RESYNC   = 3'd0,
        IDLE     = 3'd1,
        COUNT    = 3'd2,
        ACK      = 3'd3,
        DRAM     = 3'd4,
        UNMAPPED = 3'd5,
        BERR     = 3'd6
    } state_t;

    state_t           state, nextState;
    logic [CNT_W-1:0] cycleCnt, nextCnt, cntInc;
    logic [CNT_W-1:0] waitTarget, nextWait;
    logic             nextDtack;
    logic             nextBusy;
    logic             internalSel;
    logic [CNT_W-1:0] selWait;

    // Saturating increment; the counter stops at TIMEOUT rather than wrapping.
    assign cntInc = (cycleCnt >= TIMEOUT_C) ? cycleCnt : cycleCnt + CNT_W'(1);

    // Priority decode of the internal regions: ROM > RAM > IO > CAN.
    always_comb begin
        internalSel = 1'b1;
        selWait     = '0;
        if (bus.OnChipRomSelect_H)      selWait = ROM_W;
        else if (bus.OnChipRamSelect_H) selWait = RAM_W;
        else if (bus.IOSelect_H)        selWait = IO_W;
        else if (bus.CanBusSelect_H)    selWait = CAN_W;
        else                            internalSel = 1'b0;
    end

    // State and registered outputs.
    always_ff @(posedge Clock) begin
        if (!Reset_L) begin
            state       <= RESYNC;
            cycleCnt    <= '0;
            waitTarget  <= '0;
            bus.Dtack_L <= 1'b1;
            bus.CycleBusy_H <= 1'b1;
        end else begin
            state       <= nextState;
            cycleCnt    <= nextCnt;
            waitTarget  <= nextWait;
            bus.Dtack_L <= nextDtack;
            bus.CycleBusy_H <= nextBusy;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        nextState = state;
        nextCnt   = cycleCnt;
        nextWait  = waitTarget;
        case (state)
            // A cycle in flight at reset is dropped; wait for the strobe to end.
            RESYNC: begin
                if (bus.AS_L) nextState = IDLE;
            end
            IDLE: begin
                nextCnt = '0;
                if (!bus.AS_L) begin
                    if (internalSel) begin
                        nextWait  = selWait;
                        nextState = (selWait == '0) ? ACK : COUNT;
                    end else if (bus.DramSelect_H) begin
                        nextState = DRAM;
                    end else begin
                        nextState = UNMAPPED;
                    end
                end
            end
            // Counter holds clocks elapsed since the cycle was latched.
            COUNT: begin
                if (bus.AS_L) begin
                    nextState = IDLE;
                end else begin
                    nextCnt = cntInc;
                    if (cntInc == waitTarget) nextState = ACK;
                end
            end
            DRAM, UNMAPPED: begin
                if (bus.AS_L) begin
                    nextState = IDLE;
                end else begin
`ifdef BUS_TIMEOUT_EN
                    nextCnt = cntInc;
                    if (cntInc == TIMEOUT_C) nextState = BERR;
`endif
                end
            end
            ACK, BERR: begin
                if (bus.AS_L) nextState = IDLE;
            end
            default: nextState = RESYNC;
        endcase
    end

    // Output decode from the state being entered, so outputs are registered.
    always_comb begin
        nextDtack = 1'b1;
        nextBusy  = (nextState != IDLE);
        case (nextState)
            ACK:  nextDtack = 1'b0;
            // One-clock registered pass-through once the DRAM cycle is under way.
            DRAM: nextDtack = (state == DRAM) ? bus.DramDtack_L : 1'b1;
            default: nextDtack = 1'b1;
        endcase
    end

`ifdef BUS_TIMEOUT_EN
    logic nextBerr;

    assign nextBerr = (nextState != BERR);

    always_ff @(posedge Clock) begin
        if (!Reset_L) bus.Berr_L <= 1'b1;
        else          bus.Berr_L <= nextBerr;
    end
`else
    assign bus.Berr_L = 1'b1;
`endif

endmodule

// File: tb/tb_bus_ack_generator.sv
// Purpose: directed self-checking bench for bus_ack_generator with a
//          scoreboard of expected acknowledge latencies.
module tb_bus_ack_generator;

    typedef struct {
        string tag;
        int    lat;
        bit    isErr;
    } exp_t;

    logic clk = 1'b0;
    logic rstL;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    bus_ack_generator_if bus();

    bus_ack_generator #(
        .ROM_WAIT(1), .RAM_WAIT(1), .IO_WAIT(3), .CAN_WAIT(6),
        .TIMEOUT(255), .CNT_W(8)
    ) dut (
        .Clock   (clk),
        .Reset_L (rstL),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Bit order {rom, ram, io, can, dram}.
    task automatic setSel(input logic [4:0] s);
        {bus.OnChipRomSelect_H, bus.OnChipRamSelect_H, bus.IOSelect_H,
         bus.CanBusSelect_H, bus.DramSelect_H} = s;
    endtask

    // One complete bus cycle: strobe low, measure the response, hold, release.
    task automatic runCycle(input string tag, input logic [4:0] sel, input int expLat,
                            input bit isErr, input int hold);
        exp_t e;
        int   lat;
        bit   done;
        sb.push_back('{tag: tag, lat: expLat, isErr: isErr});
        setSel(sel);
        bus.AS_L = 1'b0;
        lat  = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            setSel(5'b00000);
            if (bus.Dtack_L === 1'b0 || bus.Berr_L === 1'b0) done = 1'b1;
            else if (lat >= 400) begin
                lat  = -1;
                done = 1'b1;
            end else lat++;
        end
        e = sb.pop_front();
        chk({e.tag, " latency"}, lat, e.lat);
        chk({e.tag, " dtack"}, bus.Dtack_L, e.isErr ? 1 : 0);
        chk({e.tag, " berr"}, bus.Berr_L, e.isErr ? 0 : 1);
        repeat (hold) begin
            @(negedge clk);
            chk({e.tag, " held dtack"}, bus.Dtack_L, e.isErr ? 1 : 0);
            chk({e.tag, " held berr"}, bus.Berr_L, e.isErr ? 0 : 1);
        end
        bus.AS_L = 1'b1;
        @(negedge clk);
        chk({e.tag, " release dtack"}, bus.Dtack_L, 1);
        chk({e.tag, " release berr"}, bus.Berr_L, 1);
        chk({e.tag, " release busy"}, bus.CycleBusy_H, 0);
    endtask

    // Acknowledge and error must never be low together.
    always @(negedge clk) begin
        if (rstL === 1'b1)
            chk("dtack_berr_exclusive", {31'd0, (bus.Dtack_L === 1'b0 && bus.Berr_L === 1'b0)}, 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int anyLow;
        // Reset with a live IO cycle on the bus.
        rstL = 1'b0;
        bus.AS_L = 1'b0;
        bus.DramDtack_L = 1'b1;
        setSel(5'b00100);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset dtack", bus.Dtack_L, 1);
        chk("reset berr", bus.Berr_L, 1);
        chk("reset busy", bus.CycleBusy_H, 1);
        rstL = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("resync no dtack", bus.Dtack_L, 1);
            chk("resync busy", bus.CycleBusy_H, 1);
        end
        bus.AS_L = 1'b1;
        setSel(5'b00000);
        @(negedge clk);
        chk("resync to idle", bus.CycleBusy_H, 0);

        runCycle("io after reset", 5'b00100, 3, 1'b0, 2);
        runCycle("rom", 5'b10000, 1, 1'b0, 3);
        runCycle("ram", 5'b01000, 1, 1'b0, 1);
        runCycle("io over can", 5'b00110, 3, 1'b0, 1);
        runCycle("can", 5'b00010, 6, 1'b0, 1);
        runCycle("can over dram", 5'b00011, 6, 1'b0, 0);
        runCycle("rom over all", 5'b11111, 1, 1'b0, 0);
        runCycle("io over dram", 5'b00101, 3, 1'b0, 1);

        // DRAM: controller acknowledges 4 clocks in, passed through one clock later.
        setSel(5'b00001);
        bus.AS_L = 1'b0;
        repeat (4) begin
            @(negedge clk);
            setSel(5'b00000);
            chk("dram wait dtack", bus.Dtack_L, 1);
            chk("dram busy", bus.CycleBusy_H, 1);
        end
        bus.DramDtack_L = 1'b0;
        @(negedge clk);
        chk("dram pass dtack", bus.Dtack_L, 0);
        chk("dram berr", bus.Berr_L, 1);
        bus.DramDtack_L = 1'b1;
        @(negedge clk);
        chk("dram pass deassert", bus.Dtack_L, 1);
        bus.AS_L = 1'b1;
        @(negedge clk);
        chk("dram release dtack", bus.Dtack_L, 1);
        chk("dram release busy", bus.CycleBusy_H, 0);

        // Aborted CAN cycle: strobe withdrawn before the wait expires.
        setSel(5'b00010);
        bus.AS_L = 1'b0;
        repeat (2) begin
            @(negedge clk);
            setSel(5'b00000);
            chk("abort no dtack", bus.Dtack_L, 1);
        end
        bus.AS_L = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("abort idle busy", bus.CycleBusy_H, 0);
            chk("abort stays quiet", bus.Dtack_L, 1);
        end
        runCycle("ram after abort", 5'b01000, 1, 1'b0, 0);

`ifdef BUS_TIMEOUT_EN
        runCycle("unmapped timeout", 5'b00000, 255, 1'b1, 2);
        runCycle("dram hung timeout", 5'b00001, 255, 1'b1, 1);
`else
        // Without the timeout an unmapped cycle simply waits for the strobe.
        bus.AS_L = 1'b0;
        anyLow = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.Dtack_L !== 1'b1 || bus.Berr_L !== 1'b1) anyLow++;
        end
        chk("unmapped never responds", anyLow, 0);
        chk("unmapped busy", bus.CycleBusy_H, 1);
        bus.AS_L = 1'b1;
        @(negedge clk);
        chk("unmapped release busy", bus.CycleBusy_H, 0);
`endif
        runCycle("io final", 5'b00100, 3, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
